// File: rtl/cpu_defs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cpu_defs (package)                                              |
// | Brief  : Shared constants for the register-file sequencer: opcode/op     |
// |          codes, FSM state encoding, writeback mux codes, ALU and shifter |
// |          codes, and the decoded instruction-field bundle.                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package cpu_defs;

  // Instruction classes (ir[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Sub-operation codes (ir[12:11])
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // FSM state encoding
  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_GET_A     = 3'd2;
  localparam logic [2:0] S_GET_B     = 3'd3;
  localparam logic [2:0] S_ALU       = 3'd4;
  localparam logic [2:0] S_WRITE_REG = 3'd5;
  localparam logic [2:0] S_WRITE_IMM = 3'd6;

  // Writeback mux select
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  // Datapath idle codes
  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b00;

  // Decoded instruction fields
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } fields_t;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : instr_decoder                                                   |
// | Brief  : Purely combinational field extraction and immediate sign        |
// |          extension from the latched instruction register.                |
// | Ports  : ir     - latched instruction word                               |
// |          fields - opcode/op/Rn/Rd/sh/Rm                                  |
// |          sximm8 - sign-extended ir[7:0]                                  |
// |          sximm5 - sign-extended ir[4:0]                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module instr_decoder
  import cpu_defs::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir,
  output fields_t           fields,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
);

  always_comb begin
    fields.opcode = ir[15:13];
    fields.op     = ir[12:11];
    fields.rn     = ir[10:8];
    fields.rd     = ir[7:5];
    fields.sh     = ir[4:3];
    fields.rm     = ir[2:0];
  end

  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

endmodule : instr_decoder
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : regfile_sequencer                                               |
// | Brief  : Multicycle controller. Latches one instruction on an accepted   |
// |          start strobe and sequences register-file reads/writes and the   |
// |          A/B/C/status load enables to execute it, then returns to WAIT.  |
// | Ports  : clk, reset (sync, active high)                                  |
// |          s, in          - start strobe and instruction word              |
// |          w              - ready (in WAIT)                                |
// |          readnum, writenum, write, vsel - regfile controls               |
// |          loada/b/c, loads, asel, bsel, shift, ALUop - datapath controls  |
// |          sximm8, sximm5 - sign-extended immediates from ir               |
// |          illegal        - sticky: last instruction was undefined         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module regfile_sequencer
  import cpu_defs::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic              illegal
);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [15:0] ir;
  fields_t     f;
  logic        accept;
  logic        is_mov_imm;
  logic        is_mov_reg;
  logic        is_alu;
  logic        is_mvn;
  logic        is_cmp;
  logic        write_en;

  instr_decoder #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir),
    .fields (f),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  assign accept     = (state == S_WAIT) && s;
  assign is_mov_imm = (f.opcode == OPC_MOV) && (f.op == OP_MOV_IMM);
  assign is_mov_reg = (f.opcode == OPC_MOV) && (f.op == OP_MOV_REG);
  assign is_alu     = (f.opcode == OPC_ALU);
  assign is_mvn     = is_alu && (f.op == OP_MVN);
  assign is_cmp     = is_alu && (f.op == OP_CMP);

  // Instruction register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ir      <= 16'h0000;
      illegal <= 1'b0;
    end else if (accept) begin
      ir      <= in;
      illegal <= 1'b0;
    end else if ((state == S_DECODE) && !(is_mov_imm || is_mov_reg || is_alu)) begin
      illegal <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_WAIT:      if (s) next_state = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)                 next_state = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)  next_state = S_GET_B;
        else if (is_alu)                next_state = S_GET_A;
        else                            next_state = S_WAIT;
      end
      S_GET_A:     next_state = S_GET_B;
      S_GET_B:     next_state = S_ALU;
      S_ALU:       next_state = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: next_state = S_WAIT;
      S_WRITE_IMM: next_state = S_WAIT;
      default:     next_state = S_WAIT;
    endcase
  end

  // Moore outputs
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write_en = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = SHIFT_NONE;
    ALUop    = ALU_ADD;
    case (state)
      S_WAIT:  w = 1'b1;
      S_GET_A: begin
        readnum = f.rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = f.rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = f.sh;
        ALUop = f.op;
        // MOV reg reuses the adder with a zero A operand; MVN ignores A.
        asel  = is_mov_reg || is_mvn;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WRITE_REG: begin
        writenum = f.rd;
        vsel     = VSEL_C;
        write_en = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = f.rn;
        vsel     = VSEL_IMM;
        write_en = 1'b1;
      end
      default: ;
    endcase
  end

  // A reset landing on a write cycle must not commit a partial result.
  assign write = write_en && !reset;

endmodule : regfile_sequencer
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_regfile_sequencer                                            |
// | Brief  : Scoreboard bench: stimulus pushes the expected per-cycle        |
// |          control bundle for each instruction; a negedge monitor pops and |
// |          compares against the DUT outputs.                               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_sequencer;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        illegal;
    logic [15:0] sx8;
    logic [15:0] sx5;
  } ctl_t;

  typedef struct {
    ctl_t  c;
    string name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm8, sximm5;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .in       (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (aluop),
    .sximm8   (sximm8),
    .sximm5   (sximm5),
    .illegal  (illegal)
  );

  // ---------------- expected-bundle builders ----------------
  function automatic ctl_t base(input logic [15:0] sx8, input logic [15:0] sx5);
    ctl_t c;
    c = '0;
    c.sx8 = sx8;
    c.sx5 = sx5;
    return c;
  endfunction

  task automatic push(input ctl_t c, input string name);
    exp_t e;
    e.c = c;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic p_wait(input logic ill, input logic [15:0] sx8, input logic [15:0] sx5, input string nm);
    ctl_t c;
    c = base(sx8, sx5);
    c.w = 1'b1;
    c.illegal = ill;
    push(c, nm);
  endtask

  task automatic p_decode(input logic [15:0] sx8, input logic [15:0] sx5, input string nm);
    push(base(sx8, sx5), nm);
  endtask

  task automatic p_geta(input logic [2:0] rn, input logic [15:0] sx8, input logic [15:0] sx5, input string nm);
    ctl_t c;
    c = base(sx8, sx5);
    c.readnum = rn;
    c.loada = 1'b1;
    push(c, nm);
  endtask

  task automatic p_getb(input logic [2:0] rm, input logic [15:0] sx8, input logic [15:0] sx5, input string nm);
    ctl_t c;
    c = base(sx8, sx5);
    c.readnum = rm;
    c.loadb = 1'b1;
    push(c, nm);
  endtask

  task automatic p_alu(input logic [1:0] sh, input logic [1:0] op, input logic a0, input logic cmp,
                       input logic [15:0] sx8, input logic [15:0] sx5, input string nm);
    ctl_t c;
    c = base(sx8, sx5);
    c.shift = sh;
    c.aluop = op;
    c.asel  = a0;
    c.loads = cmp;
    c.loadc = ~cmp;
    push(c, nm);
  endtask

  task automatic p_wr(input logic [2:0] rd, input logic [1:0] vs, input logic wr,
                      input logic [15:0] sx8, input logic [15:0] sx5, input string nm);
    ctl_t c;
    c = base(sx8, sx5);
    c.writenum = rd;
    c.vsel = vs;
    c.write = wr;
    push(c, nm);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ctl_t act;
      e = exp_q.pop_front();
      act = '{w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
              asel, bsel, shift, aluop, illegal, sximm8, sximm5};
      n_cmp++;
      if (act !== e.c) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.c);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drive s for one edge; returns just after the accepting edge.
  task automatic issue(input logic [15:0] word);
    @(negedge clk);
    s = 1'b1;
    instr = word;
    @(posedge clk);
    #1;
    s = 1'b0;
    instr = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    p_wait(1'b0, 16'h0000, 16'h0000, "reset_wait");
    wait_drain("reset");

    // MOV R2,#7
    issue(16'hD207);
    p_decode(16'h0007, 16'h0007, "movi7_decode");
    p_wr(3'd2, 2'b10, 1'b1, 16'h0007, 16'h0007, "movi7_write_imm");
    p_wait(1'b0, 16'h0007, 16'h0007, "movi7_wait");
    wait_drain("movi7");

    // MOV R1,#-1
    issue(16'hD1FF);
    p_decode(16'hFFFF, 16'hFFFF, "movim1_decode");
    p_wr(3'd1, 2'b10, 1'b1, 16'hFFFF, 16'hFFFF, "movim1_write_imm");
    p_wait(1'b0, 16'hFFFF, 16'hFFFF, "movim1_wait");
    wait_drain("movim1");

    // ADD R3,R1,R2
    issue(16'hA162);
    p_decode(16'h0062, 16'h0002, "add_decode");
    p_geta(3'd1, 16'h0062, 16'h0002, "add_get_a");
    p_getb(3'd2, 16'h0062, 16'h0002, "add_get_b");
    p_alu(2'b00, 2'b00, 1'b0, 1'b0, 16'h0062, 16'h0002, "add_alu");
    p_wr(3'd3, 2'b00, 1'b1, 16'h0062, 16'h0002, "add_write_reg");
    p_wait(1'b0, 16'h0062, 16'h0002, "add_wait");
    wait_drain("add");

    // CMP R1,R2 (shift 01)
    issue(16'hA94A);
    p_decode(16'h004A, 16'h000A, "cmp_decode");
    p_geta(3'd1, 16'h004A, 16'h000A, "cmp_get_a");
    p_getb(3'd2, 16'h004A, 16'h000A, "cmp_get_b");
    p_alu(2'b01, 2'b01, 1'b0, 1'b1, 16'h004A, 16'h000A, "cmp_alu");
    p_wait(1'b0, 16'h004A, 16'h000A, "cmp_wait");
    wait_drain("cmp");

    // MOV R7,R1
    issue(16'hC0E1);
    p_decode(16'hFFE1, 16'h0001, "movr_decode");
    p_getb(3'd1, 16'hFFE1, 16'h0001, "movr_get_b");
    p_alu(2'b00, 2'b00, 1'b1, 1'b0, 16'hFFE1, 16'h0001, "movr_alu");
    p_wr(3'd7, 2'b00, 1'b1, 16'hFFE1, 16'h0001, "movr_write_reg");
    p_wait(1'b0, 16'hFFE1, 16'h0001, "movr_wait");
    wait_drain("movr");

    // MVN R5,R0 (shift 10)
    issue(16'hB8B0);
    p_decode(16'hFFB0, 16'hFFF0, "mvn_decode");
    p_getb(3'd0, 16'hFFB0, 16'hFFF0, "mvn_get_b");
    p_alu(2'b10, 2'b11, 1'b1, 1'b0, 16'hFFB0, 16'hFFF0, "mvn_alu");
    p_wr(3'd5, 2'b00, 1'b1, 16'hFFB0, 16'hFFF0, "mvn_write_reg");
    p_wait(1'b0, 16'hFFB0, 16'hFFF0, "mvn_wait");
    wait_drain("mvn");

    // AND R3,R5,R3 (shift 01)
    issue(16'hB56B);
    p_decode(16'h006B, 16'h000B, "and_decode");
    p_geta(3'd5, 16'h006B, 16'h000B, "and_get_a");
    p_getb(3'd3, 16'h006B, 16'h000B, "and_get_b");
    p_alu(2'b01, 2'b10, 1'b0, 1'b0, 16'h006B, 16'h000B, "and_alu");
    p_wr(3'd3, 2'b00, 1'b1, 16'h006B, 16'h000B, "and_write_reg");
    p_wait(1'b0, 16'h006B, 16'h000B, "and_wait");
    wait_drain("and");

    // Undefined instruction
    issue(16'h0000);
    p_decode(16'h0000, 16'h0000, "undef_decode");
    p_wait(1'b1, 16'h0000, 16'h0000, "undef_wait_illegal");
    p_wait(1'b1, 16'h0000, 16'h0000, "undef_illegal_sticky");
    wait_drain("undef");

    // Next valid instruction clears illegal
    issue(16'hD207);
    p_decode(16'h0007, 16'h0007, "clr_decode");
    p_wr(3'd2, 2'b10, 1'b1, 16'h0007, 16'h0007, "clr_write_imm");
    p_wait(1'b0, 16'h0007, 16'h0007, "clr_wait");
    wait_drain("clr");

    // ADD with ignored s during GET_B and reset during WRITE_REG
    issue(16'hA162);
    p_decode(16'h0062, 16'h0002, "rst_decode");
    p_geta(3'd1, 16'h0062, 16'h0002, "rst_get_a");
    p_getb(3'd2, 16'h0062, 16'h0002, "rst_get_b");
    p_alu(2'b00, 2'b00, 1'b0, 1'b0, 16'h0062, 16'h0002, "rst_alu_ir_kept");
    p_wr(3'd3, 2'b00, 1'b0, 16'h0062, 16'h0002, "rst_write_gated");
    p_wait(1'b0, 16'h0000, 16'h0000, "rst_abort_wait");
    @(posedge clk);            // into GET_A
    @(posedge clk);            // into GET_B
    #1;
    s = 1'b1;
    instr = 16'hD1FF;
    @(posedge clk);            // into ALU; s must be ignored
    #1;
    s = 1'b0;
    instr = 16'h0000;
    @(posedge clk);            // into WRITE_REG
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_drain("rst");

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_regfile_sequencer
`default_nettype wire

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multicycle controller that fetches one latched 16-bit instruction and sequences the 8x16 register file plus A/B/C pipeline registers, shifter, ALU and status register to execute it.
- Sits between the instruction source (start strobe `s` plus instruction word) and the datapath.
- Owns every regfile read/write select and every datapath load enable.
- Returns to an idle wait state with `w` high when the instruction completes.

Parameters:
- DATA_W, 16, datapath and sign-extended immediate width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- s, input, 1, start; sampled only in WAIT.
- in, input, 16, instruction word; sampled only when s is accepted.
- w, output, 1, high while in WAIT (ready for next instruction).
- readnum, output, 3, regfile read select.
- writenum, output, 3, regfile write select.
- write, output, 1, regfile write enable.
- vsel, output, 2, writeback mux select: 00=C, 10=sximm8, others reserved.
- loada, output, 1, load A register.
- loadb, output, 1, load B register.
- loadc, output, 1, load C register.
- loads, output, 1, load status flags.
- asel, output, 1, 1 selects 0 for A operand.
- bsel, output, 1, 1 selects sximm5 for B operand.
- shift, output, 2, shifter control.
- ALUop, output, 2, ALU operation.
- sximm8, output, DATA_W, sign-extended ir[7:0].
- sximm5, output, DATA_W, sign-extended ir[4:0].
- illegal, output, 1, sticky flag: last instruction was undefined.

Behaviour:
- Instruction register `ir` (16b):
  - Loaded from `in` on a clk edge where state==WAIT and s=1.
  - Otherwise holds.
  - All decode uses `ir`, never `in`.
- Fields:
  - opcode = ir[15:13]; op = ir[12:11]; Rn = ir[10:8]; Rd = ir[7:5]; sh = ir[4:3]; Rm = ir[2:0].
- States: WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM. All outputs are Moore (state + ir).
- WAIT:
  - w=1.
  - s=1 -> DECODE (ir loaded, illegal cleared).
  - s=0 -> stay.
- DECODE:
  - 110/10 (MOV imm) -> WRITE_IMM.
  - 110/00 (MOV reg) -> GET_B.
  - 101/xx (ADD/CMP/AND/MVN) -> GET_A, except op=11 (MVN) -> GET_B.
  - Anything else -> WAIT with illegal=1; no load or write is issued.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> ALU.
- ALU:
  - shift=sh; ALUop=op; bsel=0.
  - asel=1 for MOV reg and MVN, else asel=0.
  - CMP: loads=1, loadc=0 -> WAIT.
  - Others: loadc=1 -> WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=00, write=1 -> WAIT.
- WRITE_IMM: writenum=Rn, vsel=10, write=1 -> WAIT.
- In every state, all unnamed enables are 0 and selects are 0.
- Latency, counted as edges from s accepted to w=1:
  - MOV imm = 3.
  - MOV reg = 5.
  - MVN = 5.
  - CMP = 5.
  - ADD/AND = 6.
- s asserted outside WAIT is ignored; no queueing.
- write is additionally gated by ~reset: no regfile write may occur on an edge where reset=1.
- Reset:
  - On any edge with reset=1: state=WAIT, ir=0, illegal=0.
  - Next-cycle outputs: w=1, all enables 0, selects 0.
  - Mid-instruction reset aborts the instruction with no partial writeback.
- sximm8 and sximm5 are combinational sign extensions of ir. Reset value: 0.
- The same register index for Rn/Rm/Rd is legal. A and B are read in separate cycles, so no hazard exists.

Decomposition:
- Shared package `cpu_defs`:
  - Opcode and op constants.
  - State encoding (3-bit localparams).
  - vsel codes.
  - ALUop and shift codes.
- Sub-module `instr_decoder`: combinational field extraction and sign extension from ir (Rn/Rd/Rm/sh/op/opcode, sximm8, sximm5).
- `regfile_sequencer` holds the FSM, ir and illegal.

Test Plan:
- Reset, then s=1 with in=16'hD207 (MOV R2,#7):
  - Edge after WAIT: DECODE, then WRITE_IMM with writenum=2, vsel=10, write=1, sximm8=7.
  - w=1 on the 3rd edge.
- MOV R1,#-1 (16'hD1FF):
  - sximm8 = 16'hFFFF.
- ADD R3,R1,R2 (16'hA162):
  - Sequence GET_A (readnum=1, loada), GET_B (readnum=2, loadb), ALU (ALUop=00, loadc), WRITE_REG (writenum=3, write).
  - Back in WAIT on the 6th edge.
- CMP R1,R2 (16'hA94A):
  - loads=1 exactly once.
  - write never asserted.
  - Returns to WAIT after the ALU state.
- Undefined in=16'h0000:
  - DECODE -> WAIT, illegal=1, no write or load.
  - The next valid s clears illegal.
- Reset asserted during WRITE_REG of an ADD:
  - write=0 on that edge.
  - Next cycle state=WAIT, w=1.
  - s pulses during GET_B are ignored and ir is unchanged.
